// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequencer for a time-multiplexed FIR. One multiplier and one
// accumulator walk all taps serially, one tap per clock.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   sample handshake; in_ready is high only while idle
//   in_data             signed sample (DW bits)
//   coef_we/addr/data   coefficient write port, ignored while busy
//   out_valid/out_ready result handshake
//   out_data            signed filtered result (DW bits)
//   busy                high while accumulating or finishing a result
//   sat_flag            current result was clamped
//
// Optional feature: define FIR_SAT_EN to clamp the shifted accumulator to the
// DW-bit signed range and report it on sat_flag. Without it the result wraps
// and sat_flag is tied low.
module fir_mac_seq #(
   parameter int unsigned DW    = 8,
   parameter int unsigned CW    = 8,
   parameter int unsigned TAPS  = 8,
   parameter int unsigned SHIFT = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DW-1:0]           in_data,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_addr,
   input  logic [CW-1:0]           coef_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DW-1:0]           out_data,
   output logic                    busy,
   output logic                    sat_flag
);

   localparam int unsigned AW  = $clog2(TAPS);
   localparam int unsigned PW  = DW + CW;
   localparam int unsigned ACW = PW + AW;

   typedef enum logic [1:0] {StIdle, StMac, StDone, StOut} state_e;

   state_e                 state_q, state_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          k_q, k_d;
   logic signed [ACW-1:0]  acc_q, acc_d;
   logic                   out_valid_q, out_valid_d;
   logic [DW-1:0]          out_data_q, out_data_d;
   logic signed [DW-1:0]   smp_q [TAPS];
   logic signed [CW-1:0]   coef_q [TAPS];

   logic                   accept;
   logic                   coef_take;
   logic [AW-1:0]          rd_idx;
   logic signed [PW-1:0]   prod;
   logic signed [ACW-1:0]  prod_ext;
   logic signed [ACW-1:0]  shifted;
   logic [DW-1:0]          res;
   logic                   res_sat;

   // Newest sample sits at wr_ptr; tap k reads k samples back, wrapping.
   assign rd_idx    = wr_ptr_q - k_q;
   assign prod      = PW'(coef_q[k_q]) * PW'(smp_q[rd_idx]);
   assign prod_ext  = ACW'(prod);
   assign shifted   = acc_q >>> SHIFT;
   assign coef_take = coef_we && !busy;

`ifdef FIR_SAT_EN
   localparam logic signed [ACW-1:0] SatMax = ACW'((2 ** (DW - 1)) - 1);
   localparam logic signed [ACW-1:0] SatMin = ACW'(-(2 ** (DW - 1)));

   always_comb begin
      res     = shifted[DW-1:0];
      res_sat = 1'b0;
      if (shifted > SatMax) begin
         res     = {1'b0, {(DW-1){1'b1}}};
         res_sat = 1'b1;
      end else if (shifted < SatMin) begin
         res     = {1'b1, {(DW-1){1'b0}}};
         res_sat = 1'b1;
      end
   end
`else
   logic unused_shift_msbs;

   assign res               = shifted[DW-1:0];
   assign res_sat           = 1'b0;
   assign unused_shift_msbs = ^shifted[ACW-1:DW];
`endif

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      k_d         = k_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      accept      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               accept  = 1'b1;
               acc_d   = '0;
               k_d     = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            acc_d = acc_q + prod_ext;
            k_d   = k_q + AW'(1);
            if (k_q == AW'(TAPS - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            out_data_d  = res;
            wr_ptr_d    = wr_ptr_q + AW'(1);
            out_valid_d = 1'b1;
            state_d     = StOut;
         end
         StOut: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            smp_q[i]  <= '0;
            coef_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            smp_q[wr_ptr_q] <= in_data;
         end
         if (coef_take) begin
            coef_q[coef_addr] <= coef_data;
         end
      end
   end

`ifdef FIR_SAT_EN
   logic sat_q;

   // Captured with the result and held until the next result is formed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q <= 1'b0;
      end else if (state_q == StDone) begin
         sat_q <= res_sat;
      end
   end

   assign sat_flag = sat_q;
`else
   assign sat_flag = 1'b0;
`endif

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q == StMac) || (state_q == StDone);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
module tb_fir_mac_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       coef_we;
   logic [2:0] coef_addr;
   logic [7:0] coef_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;
   logic       sat_flag;

   int n_tests = 0;
   int n_fail  = 0;

   fir_mac_seq #(
      .DW    (8),
      .CW    (8),
      .TAPS  (8),
      .SHIFT (7)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .sat_flag  (sat_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All driving and sampling happens 1 time unit after a rising edge.
   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [7:0] d);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
   endtask

   task automatic offer(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // lat counts edges after the accept edge; bcnt counts samples with busy high.
   task automatic wait_out(output int lat, output int bcnt);
      lat  = 0;
      bcnt = busy ? 1 : 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) bcnt++;
      end
      check("out_valid_seen", out_valid, 1);
   endtask

   task automatic run(input logic [7:0] d, output logic [7:0] r, output logic s);
      int lat;
      int bcnt;
      offer(d);
      wait_out(lat, bcnt);
      r = out_data;
      s = sat_flag;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int         lat;
      int         bcnt;
      logic [7:0] r;
      logic       s;
      logic [7:0] exp_imp [12];
      logic [7:0] exp_sat_data;
      logic       exp_sat_flag;

      // Reset state
      do_reset();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_sat", sat_flag, 0);

      // Latency: 64*64 >>> 7 = 32
      write_coef(3'd0, 8'd64);
      offer(8'h40);
      wait_out(lat, bcnt);
      check("lat_data", out_data, 8'h20);
      check("lat_cycles", lat, 9);
      check("lat_busy", bcnt, 9);
      check("lat_sat", sat_flag, 0);
      @(posedge clk);
      #1;
      check("lat_ov_drop", out_valid, 0);
      check("lat_ready_back", in_ready, 1);

      // Impulse through 12 samples: coef[k]=2(k+1), input 64 -> (k+1) after >>>7
      do_reset();
      for (int k = 0; k < 8; k++) write_coef(3'(k), 8'(2 * (k + 1)));
      for (int i = 0; i < 12; i++) exp_imp[i] = (i < 8) ? 8'(i + 1) : 8'd0;
      for (int i = 0; i < 12; i++) begin
         run((i == 0) ? 8'd64 : 8'd0, r, s);
         check($sformatf("impulse_%0d", i), r, exp_imp[i]);
      end

      // Backpressure: result held, nothing accepted while stalled
      do_reset();
      write_coef(3'd0, 8'd64);
      out_ready = 1'b0;
      offer(8'h40);
      wait_out(lat, bcnt);
      in_valid = 1'b1;
      in_data  = 8'h7F;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_data", out_data, 8'h20);
         check("bp_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      check("bp_still_out", in_ready, 0);
      @(posedge clk);
      #1;
      check("bp_release_ov", out_valid, 0);
      check("bp_release_busy", busy, 0);
      check("bp_release_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_accept_busy", busy, 1);
      wait_out(lat, bcnt);
      check("bp_next_data", out_data, 8'h3F);
      @(posedge clk);
      #1;

      // Coefficient write during MAC is dropped; during OUT it is taken
      do_reset();
      write_coef(3'd0, 8'd64);
      offer(8'd64);
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 8'd127;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      wait_out(lat, bcnt);
      check("wb_mac_a", out_data, 8'h20);
      @(posedge clk);
      #1;
      offer(8'd64);
      wait_out(lat, bcnt);
      check("wb_mac_b", out_data, 8'h20);
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 8'd127;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      run(8'd64, r, s);
      check("wb_out_c", r, 8'h3F);

      // Saturation: 8*127*127 = 129032, >>>7 = 1008
`ifdef FIR_SAT_EN
      exp_sat_data = 8'h7F;
      exp_sat_flag = 1'b1;
`else
      exp_sat_data = 8'hF0;
      exp_sat_flag = 1'b0;
`endif
      do_reset();
      for (int k = 0; k < 8; k++) write_coef(3'(k), 8'd127);
      for (int i = 0; i < 9; i++) run(8'd127, r, s);
      check("sat_data", r, exp_sat_data);
      check("sat_flag", s, exp_sat_flag);

      // Reset during MAC discards the partial result and coefficients
      do_reset();
      write_coef(3'd0, 8'd64);
      offer(8'd64);
      repeat (3) @(posedge clk);
      #1;
      check("mr_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mr_out_valid", out_valid, 0);
      check("mr_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("mr_in_ready", in_ready, 1);
      run(8'h10, r, s);
      check("mr_data", r, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
Sequencer for a time-multiplexed FIR datapath: one multiplier and one accumulator evaluate all taps serially, one tap per cycle.
- Accepts samples over a valid/ready input and holds the history in a circular sample buffer.
- Holds programmable coefficients in a small register file.
- Delivers each filtered result on a valid/ready output.
- Sits between a sample source and the downstream consumer, in place of a fully parallel FIR.

Parameters:
DW, 8, sample and output width (signed)
CW, 8, coefficient width (signed)
TAPS, 8, number of taps / sample buffer depth (power of two, >=2)
SHIFT, 7, arithmetic right shift applied to the accumulator before output

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample offered
in_ready  out  1  sample can be accepted
in_data  in  DW  signed sample
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index k
coef_data  in  CW  signed coefficient
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  DW  signed filtered result
busy  out  1  high in MAC or DONE
sat_flag  out  1  current result was clamped (FIR_SAT_EN only, else 0)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate):
  - state=IDLE; wr_ptr=0; acc=0; k=0.
  - All buffer entries and coefficients are 0.
  - out_valid=0, out_data=0, sat_flag=0, busy=0.
  - in_ready=1 from reset release.
- States are IDLE, MAC, DONE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (accept edge E0): buf[wr_ptr]<=in_data, acc<=0, k<=0, go to MAC.
- MAC:
  - Each edge: acc <= acc + coef[k]*buf[(wr_ptr-k) mod TAPS], then k<=k+1.
  - After the edge with k=TAPS-1 (edge E_TAPS), go to DONE.
  - Exactly TAPS MAC cycles.
- DONE (one cycle):
  - out_data <= (acc >>> SHIFT) reduced to DW bits.
  - wr_ptr <= wr_ptr+1, wrapping modulo TAPS.
  - out_valid<=1; go to OUT.
  - out_valid is therefore first high TAPS+1 cycles after E0.
- OUT:
  - out_valid=1; out_data and sat_flag are held stable.
  - On out_ready=1: out_valid<=0 and go to IDLE.
  - in_ready=0 throughout (backpressure propagates upstream).
- in_ready is high only in IDLE. Minimum sample period is TAPS+3 cycles with out_ready tied high.
- Arithmetic:
  - Two's complement throughout.
  - Product width DW+CW; acc width DW+CW+$clog2(TAPS), so no internal overflow.
  - Shift is arithmetic.
  - Without the optional feature, out_data is the low DW bits of the shifted value (wrap).
- Coefficient writes:
  - Honoured only when busy=0 (IDLE or OUT); dropped silently when busy=1.
  - A write and a sample accept on the same IDLE edge are both taken; the new coefficient applies to that sample.
- History: the first TAPS-1 results after reset use zeroed history entries.
- Reset mid-operation (any state): immediate return to reset values; the partial result is discarded, never emitted.

Optional Feature:
Macro FIR_SAT_EN.
- Defined:
  - The shifted accumulator is clamped to [-2^(DW-1), 2^(DW-1)-1] before loading out_data.
  - sat_flag<=1 in DONE when clamping occurred, else 0; held through OUT.
- Undefined:
  - Truncating wrap as above.
  - sat_flag tied to 0; no saturation logic synthesised.

Test Plan:
1. Latency: after reset, write coef[0]=64, all others 0; accept in_data=0x40 -> out_data=0x20, out_valid rises exactly 9 cycles after the accept edge; busy high for 9 cycles.
2. Impulse and wrap (SHIFT=0): coef[k]=k+1; feed 1 then eleven 0s with out_ready=1 -> outputs 1,2,3,4,5,6,7,8,0,0,0,0. wr_ptr wraps correctly.
3. Backpressure: hold out_ready=0 for 5 cycles in OUT while in_valid=1 -> out_data stable, in_ready=0, no sample accepted until the cycle after out_ready=1.
4. Write while busy: write coef[0]=127 during MAC -> ignored; next sample's result uses the old coef[0]. The same write during OUT takes effect on the next sample.
5. Saturation: all coefs 127, SHIFT=7, feed 127 nine times -> acc=129032, shifted value 1008. With FIR_SAT_EN: out_data=0x7F, sat_flag=1. Without: out_data=0xF0, sat_flag=0.
6. Reset mid-MAC: drop rst_n at MAC cycle 3 -> out_valid=0 and busy=0 immediately. After release, feed 0x10 -> out_data=0x00 (coefficients cleared).
